// File: rtl/demux2s_if.sv
// demux2s_if: bundle for the 1-to-4 registered demultiplexer.
//   d, s, in_valid, in_ready : single input stream (word + channel select)
//   o0..o3, v0..v3, r0..r3   : per-channel holding data, valid, consumer ready
//   cnt0..cnt3              : per-channel accepted-word counters (mod 256)
//   busy                    : any channel holding a word
// slave is the demux side, master is the source/consumer side.
interface demux2s_if #(
  parameter int unsigned w = 4
) ();
  localparam int unsigned CW = 8;

  logic [w-1:0]  d;
  logic [1:0]    s;
  logic          in_valid;
  logic          in_ready;
  logic [w-1:0]  o0, o1, o2, o3;
  logic          v0, v1, v2, v3;
  logic          r0, r1, r2, r3;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
  logic          busy;

  modport slave (
    input  d, s, in_valid, r0, r1, r2, r3,
    output in_ready, o0, o1, o2, o3, v0, v1, v2, v3,
           cnt0, cnt1, cnt2, cnt3, busy
  );

  modport master (
    output d, s, in_valid, r0, r1, r2, r3,
    input  in_ready, o0, o1, o2, o3, v0, v1, v2, v3,
           cnt0, cnt1, cnt2, cnt3, busy
  );
endinterface

// File: rtl/demux2s.sv
// demux2s: registered 1-to-4 demultiplexer with valid/ready handshaking.
// Steers each accepted word into the channel picked by s; every channel has a
// one-entry holding register, drains on its own ready, and counts the words
// it has accepted.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux2s_if.slave (input stream, four output channels, busy)
module demux2s #(
  parameter int unsigned w = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  demux2s_if.slave   bus
);
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;

  logic [w-1:0]   o_q   [NCH];
  logic [w-1:0]   o_d   [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] v_q, v_d;
  logic [NCH-1:0] r_c;
  logic           in_ready_c;
  logic           in_fire_c;

  assign r_c = {bus.r3, bus.r2, bus.r1, bus.r0};

  // Selected channel accepts when empty or draining this cycle (pass-through).
  assign in_ready_c = !v_q[bus.s] || r_c[bus.s];
  assign in_fire_c  = bus.in_valid && in_ready_c;

  // Per-channel next state: a load wins over a drain so nothing is lost.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      v_d[k]   = v_q[k];
      o_d[k]   = o_q[k];
      cnt_d[k] = cnt_q[k];
      if (in_fire_c && (bus.s == 2'(k))) begin
        v_d[k]   = 1'b1;
        o_d[k]   = bus.d;
        cnt_d[k] = cnt_q[k] + CW'(1);
      end else if (v_q[k] && r_c[k]) begin
        v_d[k]   = 1'b0;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        o_q[k]   <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < NCH; k++) begin
        o_q[k]   <= o_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.busy     = |v_q;
  assign bus.o0   = o_q[0];
  assign bus.o1   = o_q[1];
  assign bus.o2   = o_q[2];
  assign bus.o3   = o_q[3];
  assign bus.v0   = v_q[0];
  assign bus.v1   = v_q[1];
  assign bus.v2   = v_q[2];
  assign bus.v3   = v_q[3];
  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
  assign bus.cnt2 = cnt_q[2];
  assign bus.cnt3 = cnt_q[3];
endmodule

// File: doc/demux2s.md
# demux2s

Registered 1-to-4 demultiplexer with valid/ready handshaking: the receive-side counterpart of the team's 4:1 selector. It takes one `w`-bit word per accepted transfer on a single input stream and steers it, by a 2-bit select sent alongside the word, into one of four independent output channels. Each output channel has a one-entry holding register and keeps a per-channel transfer counter. It sits between a shared data source and four consumers that may stall independently.

## Interface
Parameters:
- `w`, 4, data width of the input word and of each output channel.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `d`  input  w  input data word.
- `s`  input  2  channel select for `d`; 0..3 selects channel 0..3.
- `in_valid`  input  1  `d`/`s` valid this cycle.
- `in_ready`  output  1  block accepts `d`/`s` this cycle.
- `o0`..`o3`  output  w  channel holding-register data.
- `v0`..`v3`  output  1  channel holds a valid word.
- `r0`..`r3`  input  1  channel consumer ready.
- `cnt0`..`cnt3`  output  8  words accepted into each channel, modulo 256.
- `busy`  output  1  OR of `v0`..`v3`.

## Operation
- An input transfer occurs on a rising edge where `in_valid && in_ready`.
- An output transfer on channel k occurs on a rising edge where `vk && rk`.
- `in_ready = !v[s] || r[s]`. This is combinational from `s`, `v*` and `r*` only, never from `in_valid`. The selected channel accepts when empty, or when it is draining in the same cycle (pass-through).
- On an input transfer to channel k: `ok` <= `d`, `vk` <= 1, `cntk` <= `cntk` + 1, wrapping 255 -> 0.
- On an output transfer on channel k with no input transfer to k in the same cycle: `vk` <= 0. `ok` holds its last value.
- On a simultaneous input transfer to k and output transfer on k: `vk` stays 1 and `ok` takes the new `d`. No bubble and no loss.
- Channels not selected by `s` are unaffected by the input side. Each drains independently on its own `rk`.
- While `vk` = 1 and `rk` = 0, `ok` and `vk` are stable. No overwrite is possible, because `in_ready` is low for `s` = k.
- `s`, `d` and `in_valid` may change freely while `in_ready` is low. Nothing is captured.
- `busy` is combinational from the `v` registers.
- Reset (`rst_n` = 0, asynchronous, any time, including mid-transfer): `o0`..`o3` = 0, `v0`..`v3` = 0, `cnt0`..`cnt3` = 0, `busy` = 0. Held words are discarded. After reset `in_ready` = 1 for every `s`.
- The first transfer is possible on the first rising edge after `rst_n` rises.

## Timing
- Latency: a word accepted at edge N is visible on `ok` with `vk` = 1 after edge N; it can be consumed at edge N+1 at the earliest.
- Throughput: one word per cycle sustained to any single channel whose consumer holds `rk` = 1. This includes back-to-back words to the same channel.
- `cntk` updates at the same edge as the accepting input transfer.
- No combinational path from `d` to any output. The only input-to-output combinational paths are `s`/`r*` -> `in_ready`.

## Test plan
- Reset and idle: assert `rst_n` = 0 mid-run with `v2` = 1 and `cnt2` = 5 -> immediately all `v*` = 0, `o*` = 0, `cnt*` = 0, `busy` = 0. After release, `in_ready` = 1 for `s` = 0..3.
- Basic steer (`w` = 8): send 0xA5 on `s` = 2 with all `r` = 0 -> after the edge `o2` = 0xA5, `v2` = 1, `cnt2` = 1, `busy` = 1. Other channels stay invalid. `in_ready` = 0 for `s` = 2 and 1 for `s` = 0.
- Backpressure: with `v2` = 1 and `r2` = 0, present 0x3C on `s` = 2 for 5 cycles -> `in_ready` = 0 and `o2` stays 0xA5. Raise `r2` -> 0x3C is accepted that edge, `o2` = 0x3C, `v2` = 1.
- Pass-through stream: `r1` = 1, send 0x01..0x10 on `s` = 1 on consecutive cycles -> `in_ready` stays 1, `o1` follows one cycle behind, 16 output transfers, `cnt1` = 16.
- Independent drain: load channels 0 and 3 (0x11, 0x33), then raise `r3` only -> `v3` clears after one edge, `v0` stays 1 with `o0` = 0x11. `busy` stays 1 until `r0` drains channel 0.
- Counter wrap: 257 transfers to channel 0 with `r0` = 1 -> `cnt0` = 1 at the end, and `cnt1`..`cnt3` = 0.
